// File: rtl/query_rx.sv
// query_rx: frames a 22-bit Gen2 Query command from decoded PIE bits.
// The frame is a 4-bit command prefix, 13 parameter bits and a 5-bit CRC.
// CRC-5 runs over the whole frame, CRC bits included, so a good frame
// leaves a zero residue. A good Query latches its fields for the tag control FSM.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse: delimiter + RTcal seen, (re)start framing
//   bit_valid    one-cycle strobe qualifying bit_data
//   bit_data     decoded bit, MSB first
//   query_valid  pulse: Query with good CRC, fields valid in the same cycle
//   crc_err      pulse: Query with bad CRC
//   not_query    pulse: prefix did not match CMD_CODE
//   dr, m, trext, sel, session, target, q : latched Query fields
module query_rx #(
  parameter logic [3:0] CMD_CODE   = 4'b1000,
  parameter logic [4:0] CRC_PRESET = 5'b01001
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       query_valid,
  output logic       crc_err,
  output logic       not_query,
  output logic       dr,
  output logic [1:0] m,
  output logic       trext,
  output logic [1:0] sel,
  output logic [1:0] session,
  output logic       target,
  output logic [3:0] q
);

  localparam int unsigned FRAME_W = 22;
  localparam int unsigned HDR_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CRC_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CRC_W-1:0]   crc_q,   crc_d;
  logic               fb;
  logic               unused_shift;

  // Values the registers take if the current bit is accepted.
  always_comb begin
    fb      = bit_data ^ crc_q[4];
    crc_d   = {crc_q[3], crc_q[2] ^ fb, crc_q[1], crc_q[0], fb};
    shift_d = {shift_q[FRAME_W-2:0], bit_data};
    cnt_d   = cnt_q + CNT_W'(1);
  end

  // Prefix and CRC bits of the shifted frame are never loaded into fields.
  assign unused_shift = ^{shift_q[FRAME_W-1], shift_d[21:18], shift_d[4]};

  // Framing FSM, CRC, shift register, result pulses and field registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      crc_q       <= CRC_PRESET;
      query_valid <= 1'b0;
      crc_err     <= 1'b0;
      not_query   <= 1'b0;
      dr          <= 1'b0;
      m           <= 2'b00;
      trext       <= 1'b0;
      sel         <= 2'b00;
      session     <= 2'b00;
      target      <= 1'b0;
      q           <= 4'b0000;
    end else begin
      query_valid <= 1'b0;
      crc_err     <= 1'b0;
      not_query   <= 1'b0;
      if (frame_start) begin
        // Restart wins over a coincident bit; any partial frame is dropped quietly.
        state_q <= HDR;
        cnt_q   <= '0;
        shift_q <= '0;
        crc_q   <= CRC_PRESET;
      end else if (bit_valid && (state_q == HDR || state_q == BODY)) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
        crc_q   <= crc_d;
        if (state_q == HDR && cnt_q == CNT_W'(HDR_W - 1)) begin
          if (shift_d[HDR_W-1:0] != CMD_CODE) begin
            not_query <= 1'b1;
            state_q   <= HOLD;
          end else begin
            state_q <= BODY;
          end
        end else if (state_q == BODY && cnt_q == CNT_W'(FRAME_W - 1)) begin
          state_q <= HOLD;
          if (crc_d == '0) begin
            query_valid <= 1'b1;
            dr          <= shift_d[17];
            m           <= shift_d[16:15];
            trext       <= shift_d[14];
            sel         <= shift_d[13:12];
            session     <= shift_d[11:10];
            target      <= shift_d[9];
            q           <= shift_d[8:5];
          end else begin
            crc_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_query_rx.sv
module tb_query_rx;

  localparam logic [3:0] CMD    = 4'b1000;
  localparam logic [4:0] PRESET = 5'b01001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       query_valid, crc_err, not_query;
  logic       dr, trext, target;
  logic [1:0] m, sel, session;
  logic [3:0] q;

  query_rx #(.CMD_CODE(CMD), .CRC_PRESET(PRESET)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .query_valid(query_valid), .crc_err(crc_err), .not_query(not_query),
    .dr(dr), .m(m), .trext(trext), .sel(sel), .session(session),
    .target(target), .q(q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_qv = 0, n_ce = 0, n_nq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-5 (x^5+x^3+1) over the first n bits of a frame, MSB first.
  function automatic logic [4:0] crc_of(input logic [21:0] bits, input int n);
    logic [4:0] c;
    logic       fbk;
    c = PRESET;
    for (int i = 0; i < n; i++) begin
      fbk = bits[21-i] ^ c[4];
      c = {c[3:0], 1'b0} ^ (fbk ? 5'b01001 : 5'b00000);
    end
    return c;
  endfunction

  function automatic logic [21:0] make_frame(input logic [3:0] pre, input logic [12:0] par);
    logic [21:0] f;
    f = {pre, par, 5'b00000};
    return {pre, par, crc_of(f, 17)};
  endfunction

  // Reference model: collects the current frame as a bit list.
  logic [21:0] m_bits;
  int          m_n;
  bit          m_act;
  logic        e_qv, e_ce, e_nq;
  logic [12:0] e_par;

  always @(posedge clk) begin
    e_qv = 1'b0; e_ce = 1'b0; e_nq = 1'b0;
    if (!reset_n) begin
      m_act = 1'b0; m_n = 0; m_bits = '0; e_par = '0;
    end else if (frame_start) begin
      m_act = 1'b1; m_n = 0; m_bits = '0;
    end else if (bit_valid && m_act) begin
      m_bits = {m_bits[20:0], bit_data};
      m_n++;
      if (m_n == 4 && m_bits[3:0] != CMD) begin
        e_nq = 1'b1; m_act = 1'b0;
      end else if (m_n == 22) begin
        m_act = 1'b0;
        if (crc_of(m_bits, 22) == 5'd0) begin
          e_qv = 1'b1; e_par = m_bits[17:5];
        end else begin
          e_ce = 1'b1;
        end
      end
    end
  end

  logic [12:0] dut_par;
  assign dut_par = {dr, m, trext, sel, session, target, q};

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic        x_qv, x_ce, x_nq;
    logic [12:0] x_par;
    if (!reset_n) begin
      x_qv = 1'b0; x_ce = 1'b0; x_nq = 1'b0; x_par = '0;
    end else begin
      x_qv = e_qv; x_ce = e_ce; x_nq = e_nq; x_par = e_par;
    end
    check("query_valid", 32'(query_valid), 32'(x_qv));
    check("crc_err",     32'(crc_err),     32'(x_ce));
    check("not_query",   32'(not_query),   32'(x_nq));
    check("fields",      32'(dut_par),     32'(x_par));
    check("onehot", 32'(32'(query_valid) + 32'(crc_err) + 32'(not_query) <= 1), 32'd1);
    n_qv += int'(query_valid === 1'b1);
    n_ce += int'(crc_err === 1'b1);
    n_nq += int'(not_query === 1'b1);
  end

  task automatic tick(input logic fs, input logic bv, input logic bd);
    @(posedge clk);
    #1;
    frame_start = fs; bit_valid = bv; bit_data = bd;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic start();
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [21:0] f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, f[21-i]);
      if (gap > 0) repeat ($urandom_range(0, gap)) tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [12:0] PAR_A = 13'b1_01_1_10_11_0_1010;

  initial begin
    logic [21:0] good, fz, f;
    int kind, n;
    logic [3:0] pre;

    idle(2);
    reset_n = 1'b1;
    check("reset_qv", 32'(query_valid), 32'd0);
    check("reset_fields", 32'(dut_par), 32'd0);

    good = make_frame(CMD, 13'd0);
    check("model_good_frame", 32'(good), 32'(22'b1000_0000000000000_10000));
    fz = make_frame(CMD, PAR_A);

    // Good all-zero Query.
    start(); send(good, 22, 0); idle(3);
    check("t1_qv_count", 32'(n_qv), 32'd1);
    check("t1_fields", 32'(dut_par), 32'd0);
    check("t1_err_count", 32'(n_ce + n_nq), 32'd0);

    // Non-zero fields, then a bad CRC must leave them untouched.
    start(); send(fz, 22, 0); idle(3);
    check("t2_qv_count", 32'(n_qv), 32'd2);
    check("t2_fields", 32'(dut_par), 32'(PAR_A));
    start(); send(good ^ 22'd1, 22, 0); idle(3);
    check("t2_ce_count", 32'(n_ce), 32'd1);
    check("t2_fields_kept", 32'(dut_par), 32'(PAR_A));

    // Wrong prefix; remaining bits ignored.
    f = {4'b1001, 18'($urandom)};
    start(); send(f, 22, 0); idle(3);
    check("t3_nq_count", 32'(n_nq), 32'd1);
    check("t3_other_counts", 32'(n_qv + n_ce), 32'd3);

    // Abort after 10 bits, then a full frame.
    start(); send(good, 10, 0); start(); send(good, 22, 0); idle(3);
    check("t4_qv_count", 32'(n_qv), 32'd3);

    // Reset mid-BODY, then bits without frame_start.
    start(); send(fz, 22, 0); idle(2);
    check("t5_fields_before", 32'(dut_par), 32'(PAR_A));
    start(); send(good, 12, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_fields_reset", 32'(dut_par), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    send(good, 22, 0); idle(3);
    check("t5_qv_count", 32'(n_qv), 32'd4);
    check("t5_no_err", 32'(n_ce + n_nq), 32'd2);

    // Bit coincident with frame_start is discarded.
    tick(1'b1, 1'b1, 1'b1);
    send(good, 22, 0); idle(3);
    check("t6_qv_count", 32'(n_qv), 32'd5);
    check("t6_nq_count", 32'(n_nq), 32'd1);

    // Randomized frames, checked cycle by cycle against the model.
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 4));
      pre  = (kind == 2) ? 4'($urandom) : CMD;
      f    = make_frame(pre, 13'($urandom));
      if (kind == 1) f = f ^ (22'd1 << $urandom_range(0, 17));
      if ($urandom_range(0, 3) == 0) send(22'($urandom), 3, 1);
      start();
      n = (kind == 3) ? int'($urandom_range(1, 21)) : 22;
      send(f, n, (it % 3 == 0) ? 2 : 0);
      if (kind == 4) send(22'($urandom), 5, 1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/query_rx.md
# query_rx

Query command receiver for the tag's reader-to-tag path. It takes decoded PIE bits one at a time and frames a 22-bit Gen2 Query command: 4-bit command code, 13 parameter bits, then a 5-bit CRC. It runs CRC-5 over the frame, using the same polynomial and preset as the tag's CRC-5 checker. On a good frame it latches the Query fields for the tag control FSM; on a bad one it raises an error pulse.

## Interface
- `CMD_CODE`, default 4'b1000: command prefix accepted as Query.
- `CRC_PRESET`, default 5'b01001: CRC-5 register preset, loaded at every frame start.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse from the PIE decoder when delimiter + RTcal are detected.
- `bit_valid` in 1: one-cycle strobe; `bit_data` is valid in the same cycle.
- `bit_data` in 1: decoded bit, sent MSB first.
- `query_valid` out 1: one-cycle pulse; the frame was a Query and the CRC passed.
- `crc_err` out 1: one-cycle pulse; the frame was a Query and the CRC failed.
- `not_query` out 1: one-cycle pulse; the 4-bit prefix did not equal `CMD_CODE`.
- `dr` out 1, `m` out 2, `trext` out 1, `sel` out 2, `session` out 2, `target` out 1, `q` out 4: latched Query fields.

## Operation
- States:
  - IDLE: wait for `frame_start`.
  - HDR: collect 4 prefix bits.
  - BODY: collect 18 bits (13 parameter bits + 5 CRC bits).
  - HOLD: ignore all bits until the next `frame_start`.
- IDLE→HDR on `frame_start`. Entry loads CRC = `CRC_PRESET` and clears the bit counter and shift register.
- `frame_start` in any state restarts at HDR with the same initialisation, aborting any partial frame silently (no pulse).
- Every accepted bit (`bit_valid`=1 in HDR or BODY):
  - shifts into the 22-bit shift register LSB, with earlier bits moving toward the MSB;
  - updates the 5-bit counter;
  - advances the CRC, with fb = bit ^ crc[4]: crc[0]←fb, crc[1]←crc[0], crc[2]←crc[1], crc[3]←crc[2]^fb, crc[4]←crc[3].
- CRC bits are fed through the register too. A correct frame leaves residue 5'b00000.
- HDR, 4th bit: if prefix ≠ `CMD_CODE`, pulse `not_query` and go to HOLD; otherwise go to BODY.
- BODY, 18th bit (22nd overall): go to HOLD.
  - If the next residue is 0: pulse `query_valid` and load the field registers. Shift-register order after the prefix is DR, M[1:0], TRext, Sel[1:0], Session[1:0], Target, Q[3:0], CRC[4:0].
  - Otherwise pulse `crc_err`; field registers keep their previous values.
- Field outputs change only on a `query_valid` load.
- `bit_valid` in IDLE or HOLD is ignored, so bits beyond 22 are ignored.
- `frame_start` and `bit_valid` in the same cycle: `frame_start` wins and the bit is discarded.
- At most one of `query_valid`, `crc_err`, `not_query` is high in any cycle.

## Timing
- Reset (`reset_n`=0, any time, including mid-frame):
  - state = IDLE, counter = 0, shift register = 0, CRC = `CRC_PRESET`;
  - `query_valid`, `crc_err`, `not_query` = 0;
  - all field outputs = 0.
- Outputs are registered. Each pulse is high exactly one cycle, in the cycle after the edge that sampled the deciding bit (latency 1).
- The field registers update on the same edge that raises `query_valid`, so fields are valid while `query_valid` is high.
- Back-to-back `bit_valid` (every cycle) is supported; there is no minimum bit spacing.
- `frame_start` may arrive in the cycle right after a result pulse.

## Test plan
- Good Query, frame_start then 22 bits 1000_0_00_0_00_00_0_0000_10000:
  - `query_valid` pulses once, 1 cycle after the last bit;
  - all fields = 0; `crc_err` = `not_query` = 0.
- Same frame with the last bit flipped (CRC 10001): `crc_err` pulses once; fields keep their values from the previous good frame.
- Prefix 1001 (4 bits), then 18 more bits: `not_query` pulses 1 cycle after bit 4; no further pulses; the later bits are ignored.
- `frame_start` after 10 bits of a good frame, followed by the full good frame:
  - only one `query_valid`, after the second frame's 22nd bit;
  - no pulse from the aborted frame.
- `reset_n` asserted low for 1 cycle mid-BODY: all outputs return to reset values at once; subsequent bits without `frame_start` produce no pulse.
- `bit_valid` coincident with `frame_start`, then the 22 good-frame bits: the coincident bit is discarded and `query_valid` pulses normally.
